// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: state encoding, cause codes,
// exception vector addresses and the PC source mux code.
package exc_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SAVE_EPC = 3'd1;
  localparam logic [2:0] ST_MEM_REQ  = 3'd2;
  localparam logic [2:0] ST_MEM_WAIT = 3'd3;
  localparam logic [2:0] ST_LOAD_PC  = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam logic [1:0] CAUSE_OPCODE = 2'd0;
  localparam logic [1:0] CAUSE_OVF    = 2'd1;
  localparam logic [1:0] CAUSE_DIV0   = 2'd2;

  localparam logic [7:0] VEC_OPCODE = 8'd253;
  localparam logic [7:0] VEC_OVF    = 8'd254;
  localparam logic [7:0] VEC_DIV0   = 8'd255;

  localparam logic [2:0] PC_SRC_DEF = 3'b000;
  localparam logic [2:0] PC_SRC_MEM = 3'b101;

  typedef struct packed {
    logic [1:0] cause;
    logic [7:0] vec;
  } exc_sel_t;

  function automatic logic [31:0] vec_addr(input logic [7:0] v);
    return {24'd0, v};
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: opcode > overflow > div-by-zero, producing
// the cause code and the exception vector byte address.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic     opcode_req,
  input  logic     ovf_req,
  input  logic     div0_req,
  output logic     hit,
  output exc_sel_t sel
);

  always_comb begin
    hit       = opcode_req | ovf_req | div0_req;
    sel.cause = CAUSE_OPCODE;
    sel.vec   = VEC_OPCODE;
    if (opcode_req) begin
      sel.cause = CAUSE_OPCODE;
      sel.vec   = VEC_OPCODE;
    end else if (ovf_req) begin
      sel.cause = CAUSE_OVF;
      sel.vec   = VEC_OVF;
    end else if (div0_req) begin
      sel.cause = CAUSE_DIV0;
      sel.vec   = VEC_DIV0;
    end
  end

endmodule

// File: rtl/exc_seq.sv
// Exception sequencer: saves EPC, fetches the handler byte from the vector
// address and loads it into the PC. Optional macro DIV0_EXC_EN adds div-by-zero.
module exc_seq
  import exc_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        opcode_exc,
  input  logic        ovf_exc,
  input  logic        div0_exc,
  input  logic [31:0] pc_in,
  input  logic [7:0]  mem_byte,
  output logic [2:0]  pc_src_sel,
  output logic        pc_write,
  output logic        epc_write,
  output logic [31:0] epc_data,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        exc_done
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_dec;
  logic [1:0] cause_q;
  logic [7:0] vec_q;
  logic       hit;
  logic       div0_req;
  exc_sel_t   sel;

`ifdef DIV0_EXC_EN
  assign div0_req = div0_exc;
`else
  logic unused_div0;
  assign div0_req    = 1'b0;
  assign unused_div0 = div0_exc;
`endif

  // The handler byte reaches the PC through the external source mux, not here.
  logic unused_mem_byte;
  assign unused_mem_byte = ^mem_byte;

  exc_prio_enc u_prio (
    .opcode_req (opcode_exc),
    .ovf_req    (ovf_exc),
    .div0_req   (div0_req),
    .hit        (hit),
    .sel        (sel)
  );

  assign cnt_dec = cnt - 3'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (hit) state_nxt = ST_SAVE_EPC;
      ST_SAVE_EPC: state_nxt = ST_MEM_REQ;
      ST_MEM_REQ:  state_nxt = (WAIT_INIT == 3'd0) ? ST_LOAD_PC : ST_MEM_WAIT;
      ST_MEM_WAIT: if (cnt_dec == 3'd0) state_nxt = ST_LOAD_PC;
      ST_LOAD_PC:  state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      cause_q <= CAUSE_OPCODE;
      vec_q   <= 8'd0;
    end else begin
      state <= state_nxt;
      // Cause and vector are captured only on IDLE exit and frozen while busy.
      if (state == ST_IDLE && hit) begin
        cause_q <= sel.cause;
        vec_q   <= sel.vec;
      end
      if (state == ST_MEM_REQ)
        cnt <= WAIT_INIT;
      else if (state == ST_MEM_WAIT)
        cnt <= cnt_dec;
    end
  end

  always_comb begin
    pc_src_sel = PC_SRC_DEF;
    pc_write   = 1'b0;
    epc_write  = 1'b0;
    epc_data   = 32'd0;
    mem_addr   = 32'd0;
    mem_rd     = 1'b0;
    exc_done   = 1'b0;
    case (state)
      ST_SAVE_EPC: begin
        epc_write = 1'b1;
        epc_data  = pc_in - 32'd4;
      end
      ST_MEM_REQ: begin
        mem_addr = vec_addr(vec_q);
        mem_rd   = 1'b1;
      end
      ST_MEM_WAIT: mem_addr = vec_addr(vec_q);
      ST_LOAD_PC: begin
        pc_src_sel = PC_SRC_MEM;
        pc_write   = 1'b1;
      end
      ST_DONE:     exc_done = 1'b1;
      default:     ;
    endcase
  end

  assign cause = cause_q;
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_exc_seq.sv
// Directed bench for exc_seq: main instance at MEM_LAT=2, plus MEM_LAT=1 and
// MEM_LAT=7 instances sharing the same stimulus for latency checks.
module tb_exc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        opcode_exc, ovf_exc, div0_exc;
  logic [31:0] pc_in;
  logic [7:0]  mem_byte;

  logic [2:0]  pc_src_sel, pc_src_sel_l1, pc_src_sel_l7;
  logic        pc_write, pc_write_l1, pc_write_l7;
  logic        epc_write, epc_write_l1, epc_write_l7;
  logic [31:0] epc_data, epc_data_l1, epc_data_l7;
  logic [31:0] mem_addr, mem_addr_l1, mem_addr_l7;
  logic        mem_rd, mem_rd_l1, mem_rd_l7;
  logic [1:0]  cause, cause_l1, cause_l7;
  logic        busy, busy_l1, busy_l7;
  logic        exc_done, exc_done_l1, exc_done_l7;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  exc_seq #(.MEM_LAT(2)) dut (
    .clk(clk), .reset(reset), .opcode_exc(opcode_exc), .ovf_exc(ovf_exc),
    .div0_exc(div0_exc), .pc_in(pc_in), .mem_byte(mem_byte),
    .pc_src_sel(pc_src_sel), .pc_write(pc_write), .epc_write(epc_write),
    .epc_data(epc_data), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .cause(cause), .busy(busy), .exc_done(exc_done)
  );

  exc_seq #(.MEM_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset), .opcode_exc(opcode_exc), .ovf_exc(ovf_exc),
    .div0_exc(div0_exc), .pc_in(pc_in), .mem_byte(mem_byte),
    .pc_src_sel(pc_src_sel_l1), .pc_write(pc_write_l1), .epc_write(epc_write_l1),
    .epc_data(epc_data_l1), .mem_addr(mem_addr_l1), .mem_rd(mem_rd_l1),
    .cause(cause_l1), .busy(busy_l1), .exc_done(exc_done_l1)
  );

  exc_seq #(.MEM_LAT(7)) dut_l7 (
    .clk(clk), .reset(reset), .opcode_exc(opcode_exc), .ovf_exc(ovf_exc),
    .div0_exc(div0_exc), .pc_in(pc_in), .mem_byte(mem_byte),
    .pc_src_sel(pc_src_sel_l7), .pc_write(pc_write_l7), .epc_write(epc_write_l7),
    .epc_data(epc_data_l7), .mem_addr(mem_addr_l7), .mem_rd(mem_rd_l7),
    .cause(cause_l7), .busy(busy_l7), .exc_done(exc_done_l7)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    opcode_exc = 1'b0;
    ovf_exc    = 1'b0;
    div0_exc   = 1'b0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  int first_pw_l1, first_pw_l7, done_l7, n_pw;

  initial begin
    reset      = 1'b1;
    opcode_exc = 1'b0;
    ovf_exc    = 1'b0;
    div0_exc   = 1'b0;
    pc_in      = 32'h0;
    mem_byte   = 8'h5A;
    tick();
    tick();

    check_eq("rst_busy",     {31'd0, busy},       32'd0);
    check_eq("rst_pc_write", {31'd0, pc_write},   32'd0);
    check_eq("rst_epc_wr",   {31'd0, epc_write},  32'd0);
    check_eq("rst_mem_rd",   {31'd0, mem_rd},     32'd0);
    check_eq("rst_mem_addr", mem_addr,            32'd0);
    check_eq("rst_cause",    {30'd0, cause},      32'd0);
    check_eq("rst_done",     {31'd0, exc_done},   32'd0);
    check_eq("rst_pc_src",   {29'd0, pc_src_sel}, 32'd0);
    check_eq("rst_epc_data", epc_data,            32'd0);

    reset = 1'b0;
    tick();

    // Overflow at pc_in=0x40, latency checked on all three instances.
    ovf_exc = 1'b1;
    pc_in   = 32'h40;
    check_eq("ovf_c0_busy", {31'd0, busy}, 32'd0);
    first_pw_l1 = -1;
    first_pw_l7 = -1;
    done_l7     = -1;
    n_pw        = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (pc_write) n_pw++;
      if (pc_write_l1 && first_pw_l1 < 0) first_pw_l1 = c;
      if (pc_write_l7 && first_pw_l7 < 0) first_pw_l7 = c;
      if (exc_done_l7 && done_l7 < 0) done_l7 = c;
      case (c)
        1: begin
          check_eq("ovf_c1_epc_wr",   {31'd0, epc_write}, 32'd1);
          check_eq("ovf_c1_epc_data", epc_data,           32'h3C);
          check_eq("ovf_c1_busy",     {31'd0, busy},      32'd1);
          check_eq("ovf_c1_cause",    {30'd0, cause},     32'd1);
          check_eq("ovf_c1_mem_rd",   {31'd0, mem_rd},    32'd0);
          ovf_exc = 1'b0;
        end
        2: begin
          check_eq("ovf_c2_mem_rd",   {31'd0, mem_rd},    32'd1);
          check_eq("ovf_c2_mem_addr", mem_addr,           32'd254);
          check_eq("ovf_c2_epc_wr",   {31'd0, epc_write}, 32'd0);
        end
        3: begin
          check_eq("ovf_c3_mem_rd",   {31'd0, mem_rd},   32'd0);
          check_eq("ovf_c3_mem_addr", mem_addr,          32'd254);
          check_eq("ovf_c3_pc_write", {31'd0, pc_write}, 32'd0);
        end
        4: begin
          check_eq("ovf_c4_pc_write", {31'd0, pc_write},   32'd1);
          check_eq("ovf_c4_pc_src",   {29'd0, pc_src_sel}, 32'd5);
        end
        5: begin
          check_eq("ovf_c5_done",     {31'd0, exc_done},   32'd1);
          check_eq("ovf_c5_pc_write", {31'd0, pc_write},   32'd0);
          check_eq("ovf_c5_pc_src",   {29'd0, pc_src_sel}, 32'd0);
        end
        6: begin
          check_eq("ovf_c6_busy", {31'd0, busy},     32'd0);
          check_eq("ovf_c6_done", {31'd0, exc_done}, 32'd0);
        end
        default: ;
      endcase
    end
    check_eq("lat2_pw_count", n_pw,        32'd1);
    check_eq("lat1_pw_cycle", first_pw_l1, 32'd3);
    check_eq("lat7_pw_cycle", first_pw_l7, 32'd9);
    check_eq("lat7_done_cyc", done_l7,     32'd10);
    wait_idle();

    // Opcode and overflow together: opcode wins, overflow not serviced later.
    opcode_exc = 1'b1;
    ovf_exc    = 1'b1;
    pc_in      = 32'h100;
    tick();
    check_eq("both_c1_cause",    {30'd0, cause}, 32'd0);
    check_eq("both_c1_epc_data", epc_data,       32'hFC);
    opcode_exc = 1'b0;
    tick();
    check_eq("both_c2_mem_addr", mem_addr,       32'd253);
    check_eq("both_c2_cause",    {30'd0, cause}, 32'd0);
    tick();
    tick();
    check_eq("both_c4_pc_write", {31'd0, pc_write}, 32'd1);
    tick();
    check_eq("both_c5_done", {31'd0, exc_done}, 32'd1);
    ovf_exc = 1'b0;
    tick();
    check_eq("both_c6_busy", {31'd0, busy}, 32'd0);
    tick();
    check_eq("both_c7_busy", {31'd0, busy}, 32'd0);
    wait_idle();

    // EPC wrap at pc_in = 0.
    opcode_exc = 1'b1;
    pc_in      = 32'h0;
    tick();
    check_eq("wrap_epc_data", epc_data,           32'hFFFF_FFFC);
    check_eq("wrap_epc_wr",   {31'd0, epc_write}, 32'd1);
    wait_idle();

    // Reset in MEM_WAIT aborts with no pc_write.
    ovf_exc = 1'b1;
    pc_in   = 32'h80;
    tick();
    ovf_exc = 1'b0;
    tick();
    tick();
    check_eq("abort_c3_busy",   {31'd0, busy},     32'd1);
    check_eq("abort_c3_mem_rd", {31'd0, mem_rd},   32'd0);
    check_eq("abort_c3_cause",  {30'd0, cause},    32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy",     {31'd0, busy},     32'd0);
    check_eq("abort_pc_write", {31'd0, pc_write}, 32'd0);
    check_eq("abort_cause",    {30'd0, cause},    32'd0);
    check_eq("abort_mem_addr", mem_addr,          32'd0);
    n_pw = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pc_write || busy) n_pw++;
    end
    check_eq("abort_quiet", n_pw, 32'd0);
    wait_idle();

    // Request held through DONE restarts a new sequence.
    opcode_exc = 1'b1;
    pc_in      = 32'h200;
    for (int i = 0; i < 5; i++) tick();
    check_eq("hold_c5_done", {31'd0, exc_done}, 32'd1);
    tick();
    check_eq("hold_c6_busy", {31'd0, busy}, 32'd0);
    tick();
    check_eq("hold_c7_busy",   {31'd0, busy},      32'd1);
    check_eq("hold_c7_epc_wr", {31'd0, epc_write}, 32'd1);
    wait_idle();

    // Divide-by-zero alone.
    div0_exc = 1'b1;
    pc_in    = 32'h20;
    tick();
    div0_exc = 1'b0;
`ifdef DIV0_EXC_EN
    check_eq("div0_c1_busy", {31'd0, busy}, 32'd1);
    tick();
    check_eq("div0_c2_mem_addr", mem_addr,       32'd255);
    check_eq("div0_c2_cause",    {30'd0, cause}, 32'd2);
`else
    check_eq("div0_c1_busy", {31'd0, busy}, 32'd0);
    tick();
    check_eq("div0_c2_busy",  {31'd0, busy},   32'd0);
    check_eq("div0_c2_cause", {30'd0, cause},  32'd0);
`endif
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
